// File: rtl/fpga_cfg_pkg.sv
// Shared parameters, derived byte counts, FSM state type and checksum helper
// for the fabric configuration loader.
package fpga_cfg_pkg;

    localparam int N_LUT = 8;            // number of LUTs
    localparam int LUT_W = 33;           // {mode bit, 32-bit truth table}
    localparam int N_SB  = 5;            // number of switch boxes
    localparam int SB_W  = 16;           // switch-box configure width
    localparam logic [7:0] SYNC = 8'hA5; // frame start byte

    // Bytes per record, rounded up to whole bytes
    localparam int LB  = (LUT_W + 7) / 8;
    localparam int SBB = (SB_W + 7) / 8;

    // Counter widths sized for the larger of the two record kinds
    localparam int IDX_W = $clog2((N_LUT > N_SB) ? N_LUT : N_SB);
    localparam int CNT_W = $clog2((LB > SBB) ? LB : SBB);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LUT    = 3'd1,
        ST_SB     = 3'd2,
        ST_CHECK  = 3'd3,
        ST_COMMIT = 3'd4
    } cfg_state_e;

    // Running XOR checksum over payload bytes
    function automatic logic [7:0] cks_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/cfg_word_shifter.sv
// Byte-serial, MSB-first word assembler. 'word' already includes the byte
// presented this cycle, so the FSM can store a record on its last byte.
module cfg_word_shifter #(
    parameter int W  = 33,
    parameter int NB = 5
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [7:0]   byte_i,
    input  logic         shift_en,
    input  logic         clr,
    output logic [W-1:0] word
);

    // Only the previous NB-1 bytes need storing; the newest byte comes from byte_i
    localparam int SW = (NB - 1) * 8;

    logic [SW-1:0]   sh_q;
    logic [SW-1:0]   sh_d;
    logic [NB*8-1:0] shifted_s;

    assign shifted_s = {sh_q, byte_i};
    // Excess high bits of the first byte fall off here
    assign word      = W'(shifted_s);

    // Next shift-register contents: clear wins over shift
    always_comb begin
        sh_d = sh_q;
        if (clr) begin
            sh_d = '0;
        end else if (shift_en) begin
            sh_d = SW'(shifted_s);
        end else begin
            sh_d = sh_q;
        end
    end

    // Shift-register state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

endmodule

// File: rtl/fpga_config_loader.sv
// Byte-serial configuration writer: loads LUT and switch-box words into
// shadow registers, verifies an XOR checksum, then commits atomically.
module fpga_config_loader
    import fpga_cfg_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [7:0]             cfg_data,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic [N_LUT*LUT_W-1:0] lut_cfg,
    output logic [N_SB*SB_W-1:0]   sb_cfg,
    output logic                   fabric_enable,
    output logic                   cfg_done,
    output logic                   cfg_error,
    output logic                   busy
);

    cfg_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       cks_q, cks_d;
    logic [N_LUT-1:0][LUT_W-1:0] shadow_lut_q, shadow_lut_d;
    logic [N_SB-1:0][SB_W-1:0]   shadow_sb_q, shadow_sb_d;
    logic [N_LUT*LUT_W-1:0] lut_cfg_q, lut_cfg_d;
    logic [N_SB*SB_W-1:0]   sb_cfg_q, sb_cfg_d;
    logic fabric_enable_q, fabric_enable_d;
    logic cfg_done_q, cfg_done_d;
    logic cfg_error_q, cfg_error_d;
    logic cfg_ready_q, busy_q;

    logic             xfer_s, lut_shift_s, sb_shift_s, clr_s;
    logic [LUT_W-1:0] lut_word_s;
    logic [SB_W-1:0]  sb_word_s;

    assign xfer_s        = cfg_valid & cfg_ready_q;
    assign cfg_ready     = cfg_ready_q;
    assign busy          = busy_q;
    assign lut_cfg       = lut_cfg_q;
    assign sb_cfg        = sb_cfg_q;
    assign fabric_enable = fabric_enable_q;
    assign cfg_done      = cfg_done_q;
    assign cfg_error     = cfg_error_q;

    cfg_word_shifter #(.W(LUT_W), .NB(LB)) u_lut_shift (
        .clock(clock), .reset_n(reset_n), .byte_i(cfg_data),
        .shift_en(lut_shift_s), .clr(clr_s), .word(lut_word_s)
    );

    cfg_word_shifter #(.W(SB_W), .NB(SBB)) u_sb_shift (
        .clock(clock), .reset_n(reset_n), .byte_i(cfg_data),
        .shift_en(sb_shift_s), .clr(clr_s), .word(sb_word_s)
    );

    // Frame FSM: next state, counters, checksum, shadow writes and commit
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        cks_d           = cks_q;
        shadow_lut_d    = shadow_lut_q;
        shadow_sb_d     = shadow_sb_q;
        lut_cfg_d       = lut_cfg_q;
        sb_cfg_d        = sb_cfg_q;
        fabric_enable_d = fabric_enable_q;
        cfg_done_d      = 1'b0;
        cfg_error_d     = cfg_error_q;
        lut_shift_s     = 1'b0;
        sb_shift_s      = 1'b0;
        clr_s           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s && (cfg_data == SYNC)) begin
                    clr_s       = 1'b1;
                    cnt_d       = '0;
                    idx_d       = '0;
                    cks_d       = 8'h00;
                    cfg_error_d = 1'b0;
                    state_d     = ST_LUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LUT: begin
                if (xfer_s) begin
                    lut_shift_s = 1'b1;
                    cks_d       = cks_next(cks_q, cfg_data);
                    if (cnt_q == CNT_W'(LB - 1)) begin
                        shadow_lut_d[idx_q] = lut_word_s;
                        cnt_d               = '0;
                        if (idx_q == IDX_W'(N_LUT - 1)) begin
                            idx_d   = '0;
                            state_d = ST_SB;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_LUT;
                end
            end
            ST_SB: begin
                if (xfer_s) begin
                    sb_shift_s = 1'b1;
                    cks_d      = cks_next(cks_q, cfg_data);
                    if (cnt_q == CNT_W'(SBB - 1)) begin
                        shadow_sb_d[idx_q] = sb_word_s;
                        cnt_d              = '0;
                        if (idx_q == IDX_W'(N_SB - 1)) begin
                            idx_d   = '0;
                            state_d = ST_CHECK;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_SB;
                end
            end
            ST_CHECK: begin
                if (xfer_s) begin
                    if (cfg_data == cks_q) begin
                        state_d = ST_COMMIT;
                    end else begin
                        cfg_error_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_COMMIT: begin
                lut_cfg_d       = shadow_lut_q;
                sb_cfg_d        = shadow_sb_q;
                fabric_enable_d = 1'b1;
                cfg_done_d      = 1'b1;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; ready/busy look ahead at state_d
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            idx_q           <= '0;
            cks_q           <= 8'h00;
            shadow_lut_q    <= '0;
            shadow_sb_q     <= '0;
            lut_cfg_q       <= '0;
            sb_cfg_q        <= '0;
            fabric_enable_q <= 1'b0;
            cfg_done_q      <= 1'b0;
            cfg_error_q     <= 1'b0;
            cfg_ready_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            cks_q           <= cks_d;
            shadow_lut_q    <= shadow_lut_d;
            shadow_sb_q     <= shadow_sb_d;
            lut_cfg_q       <= lut_cfg_d;
            sb_cfg_q        <= sb_cfg_d;
            fabric_enable_q <= fabric_enable_d;
            cfg_done_q      <= cfg_done_d;
            cfg_error_q     <= cfg_error_d;
            cfg_ready_q     <= (state_d != ST_COMMIT);
            busy_q          <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Self-checking bench for fpga_config_loader: vector table of frame scenarios,
// scoreboard of expected commits, and hand-written reset / back-to-back cases.
module tb_fpga_config_loader;
    import fpga_cfg_pkg::*;

    localparam int LW  = N_LUT * LUT_W;
    localparam int SWD = N_SB * SB_W;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic cfg_valid = 1'b0;
    logic cfg_ready, fabric_enable, cfg_done, cfg_error, busy;
    logic [LW-1:0]  lut_cfg;
    logic [SWD-1:0] sb_cfg;

    fpga_config_loader dut (
        .clock(clock), .reset_n(reset_n), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .lut_cfg(lut_cfg), .sb_cfg(sb_cfg),
        .fabric_enable(fabric_enable), .cfg_done(cfg_done), .cfg_error(cfg_error),
        .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [N_LUT-1:0][LUT_W-1:0] lut;
        logic [N_SB-1:0][SB_W-1:0]   sb;
        logic [6:0]                  pad;
    } frame_t;

    typedef struct {
        logic [LW-1:0]  lut;
        logic [SWD-1:0] sb;
        int             done_cyc;
    } exp_t;

    typedef struct {
        int kind;       // 0 = reference frame, 1 = random, 2 = random with 8'hA5 payload
        int junk;
        int gap;        // percent chance of idle cycles before each byte
        bit good;
        bit exp_err;
        int exp_done;
        int exp_rdy_low;
    } vec_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int rdy_low = 0;
    bit cnt_en = 1'b0;
    logic [LW-1:0]  last_lut = '0;
    logic [SWD-1:0] last_sb = '0;

    task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic frame_t make_frame(input int kind);
        frame_t f;
        for (int k = 0; k < N_LUT; k++) begin
            if (kind == 0) f.lut[k] = {1'(k & 1), 32'h1000_0000 + 32'(k)};
            else           f.lut[k] = {1'($urandom), 32'($urandom)};
        end
        for (int k = 0; k < N_SB; k++) begin
            if (kind == 0) f.sb[k] = 16'h0F00 + 16'(k);
            else           f.sb[k] = 16'($urandom);
        end
        f.pad = (kind == 0) ? 7'h00 : 7'($urandom);
        if (kind == 2) begin
            f.lut[2][31:24] = 8'hA5;
            f.sb[0]         = 16'hA5A5;
        end
        return f;
    endfunction

    // Present one byte and hold it until a transfer edge has passed
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        for (int g = 0; g < 4; g++) begin
            if (int'($urandom_range(99, 0)) < gap) begin
                cfg_valid = 1'b0;
                @(posedge clock); #1;
            end
        end
        cfg_data  = b;
        cfg_valid = 1'b1;
        for (int t = 0; t < 8 && !ok; t++) begin
            ok = cfg_ready;
            @(posedge clock); #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout byte=%h", b);
        end
    endtask

    // SYNC + first n_pay bytes of the frame; full good frames go to the scoreboard
    task automatic send_frame(input frame_t f, input int gap, input bit good, input int n_pay);
        logic [7:0] q[$];
        logic [7:0] ck = 8'h00;
        for (int k = 0; k < N_LUT; k++) begin
            q.push_back({f.pad, f.lut[k][LUT_W-1]});
            for (int j = 3; j >= 0; j--) q.push_back(f.lut[k][j*8 +: 8]);
        end
        for (int k = 0; k < N_SB; k++) begin
            q.push_back(f.sb[k][15:8]);
            q.push_back(f.sb[k][7:0]);
        end
        for (int i = 0; i < q.size(); i++) ck = ck ^ q[i];
        q.push_back(good ? ck : (ck ^ 8'h01));
        send_byte(SYNC, gap);
        for (int i = 0; i < q.size() && i < n_pay; i++) send_byte(q[i], gap);
        cfg_valid = 1'b0;
        if (good && n_pay >= q.size()) begin
            last_lut = f.lut;
            last_sb  = f.sb;
            sb_q.push_back('{f.lut, f.sb, cyc + 1});
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 6 && busy; t++) begin
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, "_lut"}, lut_cfg, LW'(0));
        check({nm, "_sb"}, LW'(sb_cfg), LW'(0));
        check({nm, "_flags"}, LW'({fabric_enable, cfg_done, cfg_error, busy, cfg_ready}), LW'(0));
    endtask

    // Cycle counter advanced on every active edge
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Monitor: ready-low accounting and scoreboard pop on every commit pulse
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (reset_n && cnt_en && !cfg_ready) rdy_low++;
        if (reset_n && cfg_done) begin
            done_cnt++;
            check("done_expected", LW'(sb_q.size() != 0), LW'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_lut", lut_cfg, e.lut);
                check("sb_sbcfg", LW'(sb_cfg), LW'(e.sb));
                check("sb_latency", LW'(cyc), LW'(e.done_cyc));
                check("sb_err_at_done", LW'(cfg_error), LW'(0));
                check("sb_enable_at_done", LW'(fabric_enable), LW'(1));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        logic [7:0] junk_b[3];
        frame_t f, fa, fb;
        int d0;

        vt[0] = '{0, 0, 0,  1'b1, 1'b0, 1, 1};   // reference frame, continuous valid
        vt[1] = '{1, 0, 0,  1'b0, 1'b1, 0, 0};   // bad checksum after a good frame
        vt[2] = '{0, 3, 0,  1'b1, 1'b0, 1, 1};   // leading junk then reference frame
        vt[3] = '{2, 0, 50, 1'b1, 1'b0, 1, 1};   // gaps, SYNC value in payload
        vt[4] = '{1, 0, 30, 1'b0, 1'b1, 0, 0};   // bad checksum with gaps
        vt[5] = '{1, 2, 0,  1'b1, 1'b0, 1, 1};   // good frame clears the error
        junk_b[0] = 8'h00;
        junk_b[1] = 8'hFF;
        junk_b[2] = 8'h5A;

        #3;
        check_reset_state("rst");
        #20 reset_n = 1'b1;
        @(posedge clock); #1;
        check("rst_ready_rise", LW'(cfg_ready), LW'(1));

        for (int v = 0; v < 6; v++) begin
            f = make_frame(vt[v].kind);
            d0 = done_cnt;
            rdy_low = 0;
            cnt_en = 1'b1;
            for (int j = 0; j < vt[v].junk; j++) send_byte(junk_b[j], 0);
            send_frame(f, vt[v].gap, vt[v].good, 1000);
            wait_idle();
            cnt_en = 1'b0;
            check("vec_err", LW'(cfg_error), LW'(vt[v].exp_err));
            check("vec_busy", LW'(busy), LW'(0));
            check("vec_done_cnt", LW'(done_cnt - d0), LW'(vt[v].exp_done));
            check("vec_ready_low", LW'(rdy_low), LW'(vt[v].exp_rdy_low));
            check("vec_enable", LW'(fabric_enable), LW'(1));
            check("vec_lut", lut_cfg, last_lut);
            check("vec_sb", LW'(sb_cfg), LW'(last_sb));
            if (vt[v].kind == 0) begin
                check("ref_lut3", LW'(lut_cfg[3*LUT_W +: LUT_W]), LW'(33'h1_1000_0003));
                check("ref_sb4", LW'(sb_cfg[4*SB_W +: SB_W]), LW'(16'h0F04));
            end
        end

        // Reset in the middle of a frame, then a clean reload
        f = make_frame(1);
        send_frame(f, 0, 1'b1, 20);
        #2 reset_n = 1'b0;
        #1;
        check_reset_state("midrst");
        last_lut = '0;
        last_sb  = '0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("midrst_ready", LW'(cfg_ready), LW'(1));
        d0 = done_cnt;
        f = make_frame(0);
        send_frame(f, 0, 1'b1, 1000);
        wait_idle();
        check("reload_done_cnt", LW'(done_cnt - d0), LW'(1));
        check("reload_lut", lut_cfg, LW'(f.lut));
        check("reload_sb", LW'(sb_cfg), LW'(f.sb));
        check("reload_enable", LW'(fabric_enable), LW'(1));

        // Back-to-back frames with no idle cycles between them
        d0 = done_cnt;
        fa = make_frame(1);
        fb = make_frame(2);
        send_frame(fa, 0, 1'b1, 1000);
        send_frame(fb, 0, 1'b1, 1000);
        wait_idle();
        check("b2b_done_cnt", LW'(done_cnt - d0), LW'(2));
        check("b2b_lut", lut_cfg, LW'(fb.lut));
        check("b2b_sb", LW'(sb_cfg), LW'(fb.sb));
        check("b2b_err", LW'(cfg_error), LW'(0));

        check("sb_empty", LW'(sb_q.size()), LW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
